// File: rtl/lane_pack_collector.sv
// Packs a stream of BEAT_W-bit beats into one BEATS-lane word (beat k in lane k),
// with early close on in_last, a one-word output register and one held word.
module lane_pack_collector #(
    parameter int BEAT_W = 32,
    parameter int BEATS  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [BEAT_W-1:0]               in_data,
    input  logic                            in_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [BEAT_W*BEATS-1:0]         out_data,
    output logic [$clog2(BEATS+1)-1:0]      out_count
);

    localparam int IDX_W = $clog2(BEATS);
    localparam int CNT_W = $clog2(BEATS+1);

    typedef logic [BEATS-1:0][BEAT_W-1:0] word_t;

    word_t             col_q, col_d;
    word_t             out_q, out_d;
    word_t             merged;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  col_cnt_q, col_cnt_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]  beat_cnt;
    logic              col_full_q, col_full_d;
    logic              out_valid_q, out_valid_d;
    logic              accept, slot_free, complete;

    assign in_ready  = !col_full_q;
    assign accept    = in_valid && in_ready;
    assign slot_free = !out_valid_q || out_ready;
    assign complete  = accept && (in_last || idx_q == IDX_W'(BEATS-1));
    assign beat_cnt  = CNT_W'(idx_q) + CNT_W'(1);

    // Lanes above idx_q are already zero because the collection is cleared per word.
    always_comb begin
        merged        = col_q;
        merged[idx_q] = in_data;
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        col_d       = col_q;
        out_d       = out_q;
        idx_d       = idx_q;
        col_cnt_d   = col_cnt_q;
        out_cnt_d   = out_cnt_q;
        col_full_d  = col_full_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (col_full_q && slot_free) begin
            // Held word drains first; in_ready is low this cycle so no beat competes.
            out_d       = col_q;
            out_cnt_d   = col_cnt_q;
            out_valid_d = 1'b1;
            col_d       = '0;
            col_full_d  = 1'b0;
        end else if (complete) begin
            idx_d = '0;
            if (slot_free) begin
                out_d       = merged;
                out_cnt_d   = beat_cnt;
                out_valid_d = 1'b1;
                col_d       = '0;
            end else begin
                col_d      = merged;
                col_cnt_d  = beat_cnt;
                col_full_d = 1'b1;
            end
        end else if (accept) begin
            col_d = merged;
            idx_d = idx_q + IDX_W'(1);
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            out_q       <= '0;
            idx_q       <= '0;
            col_cnt_q   <= '0;
            out_cnt_q   <= '0;
            col_full_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            out_q       <= out_d;
            idx_q       <= idx_d;
            col_cnt_q   <= col_cnt_d;
            out_cnt_q   <= out_cnt_d;
            col_full_q  <= col_full_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_q;
    assign out_count = out_cnt_q;

endmodule
